// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline hold/flush scheduler.
//   - pipe_state_e : FSM state encodings (PIPE_RUN, PIPE_MEM_WAIT, PIPE_DIV_WAIT)
//   - HOLD_ENABLE / HOLD_DISABLE, FLUSH_ENABLE / FLUSH_DISABLE : control levels
//   - reg_match()  : source-register versus destination-register compare
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    PIPE_RUN      = 2'd0,
    PIPE_MEM_WAIT = 2'd1,
    PIPE_DIV_WAIT = 2'd2
  } pipe_state_e;

  localparam logic HOLD_ENABLE   = 1'b1;
  localparam logic HOLD_DISABLE  = 1'b0;
  localparam logic FLUSH_ENABLE  = 1'b1;
  localparam logic FLUSH_DISABLE = 1'b0;

  // A source only conflicts when the instruction actually reads it.
  function automatic logic reg_match(input logic                  used,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detector.
// Ports:
//   id_rs1_addr/id_rs2_addr : source registers of the ID instruction
//   id_rs1_used/id_rs2_used : ID instruction reads that source
//   ex_load                 : EX instruction is a load
//   ex_reg_w_addr           : destination register of the EX instruction
//   load_use                : ID needs the load result one cycle too early
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_reg_w_addr,
  output logic                  load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_load && (ex_reg_w_addr != '0) &&
                    (reg_match(id_rs1_used, id_rs1_addr, ex_reg_w_addr) ||
                     reg_match(id_rs2_used, id_rs2_addr, ex_reg_w_addr));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central hold/flush scheduler for the 5-stage RV32 pipeline.
// Ports:
//   clk_100MHz, arst_n            : clock, asynchronous active-low reset
//   id_rs*_addr, id_rs*_used      : ID-stage source operands
//   ex_load, ex_reg_w_addr        : EX-stage load and its destination
//   ex_jump                       : taken jump/branch resolved in EX
//   mem_req, mem_ready            : data-memory access handshake
//   div_start, div_done           : iterative divider handshake
//   hold_*                        : freeze PC / pipeline registers (combinational)
//   flush_*                       : load a bubble into pipeline registers (combinational)
//   mem_timeout                   : one-cycle pulse after an aborted memory access
//   stall_cnt                     : saturating count of cycles with hold_pc=1
//
// state         | meaning
// --------------+-----------------------------------------------------------
// PIPE_RUN      | normal flow; jump and load-use handled here
// PIPE_MEM_WAIT | data access outstanding, watchdog wait_cnt running
// PIPE_DIV_WAIT | divider busy; a memory stall may override outputs
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk_100MHz,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_reg_w_addr,
  input  logic                  ex_jump,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  div_start,
  input  logic                  div_done,
  output logic                  hold_pc,
  output logic                  hold_if_id,
  output logic                  hold_id_ex,
  output logic                  hold_ex_mem,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  flush_mem_wb,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  pipe_state_e        state_q, state_d;
  logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_stall;
  logic div_stall;

  hazard_detect u_hazard_detect (
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .ex_load       (ex_load),
    .ex_reg_w_addr (ex_reg_w_addr),
    .load_use      (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;
  assign div_stall = div_start && !div_done;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = 1'b0;
    hold_pc       = HOLD_DISABLE;
    hold_if_id    = HOLD_DISABLE;
    hold_id_ex    = HOLD_DISABLE;
    hold_ex_mem   = HOLD_DISABLE;
    flush_if_id   = FLUSH_DISABLE;
    flush_id_ex   = FLUSH_DISABLE;
    flush_ex_mem  = FLUSH_DISABLE;
    flush_mem_wb  = FLUSH_DISABLE;

    unique case (state_q)
      PIPE_RUN: begin
        wait_cnt_d = '0;
        if (mem_stall) begin
          hold_pc      = HOLD_ENABLE;
          hold_if_id   = HOLD_ENABLE;
          hold_id_ex   = HOLD_ENABLE;
          hold_ex_mem  = HOLD_ENABLE;
          flush_mem_wb = FLUSH_ENABLE;
          state_d      = PIPE_MEM_WAIT;
        end else if (div_stall) begin
          hold_pc      = HOLD_ENABLE;
          hold_if_id   = HOLD_ENABLE;
          hold_id_ex   = HOLD_ENABLE;
          flush_ex_mem = FLUSH_ENABLE;
          state_d      = PIPE_DIV_WAIT;
        end else if (ex_jump) begin
          // A jump also cancels any load-use stall: the dependent instruction is flushed.
          flush_if_id  = FLUSH_ENABLE;
          flush_id_ex  = FLUSH_ENABLE;
        end else if (load_use) begin
          hold_pc      = HOLD_ENABLE;
          hold_if_id   = HOLD_ENABLE;
          flush_id_ex  = FLUSH_ENABLE;
        end
      end

      PIPE_MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = PIPE_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_LAST) begin
          // Abort: release the pipe and bubble MEM/WB so the access writes nothing.
          flush_mem_wb  = FLUSH_ENABLE;
          state_d       = PIPE_RUN;
          wait_cnt_d    = '0;
          mem_timeout_d = 1'b1;
        end else begin
          hold_pc      = HOLD_ENABLE;
          hold_if_id   = HOLD_ENABLE;
          hold_id_ex   = HOLD_ENABLE;
          hold_ex_mem  = HOLD_ENABLE;
          flush_mem_wb = FLUSH_ENABLE;
          wait_cnt_d   = wait_cnt_q + WC_W'(1);
        end
      end

      PIPE_DIV_WAIT: begin
        // A memory stall borrows the outputs without leaving the divider wait.
        if (mem_stall) begin
          hold_pc      = HOLD_ENABLE;
          hold_if_id   = HOLD_ENABLE;
          hold_id_ex   = HOLD_ENABLE;
          hold_ex_mem  = HOLD_ENABLE;
          flush_mem_wb = FLUSH_ENABLE;
        end else if (!div_done) begin
          hold_pc      = HOLD_ENABLE;
          hold_if_id   = HOLD_ENABLE;
          hold_id_ex   = HOLD_ENABLE;
          flush_ex_mem = FLUSH_ENABLE;
        end
        if (div_done) begin
          state_d = PIPE_RUN;
        end
      end

      default: begin
        state_d    = PIPE_RUN;
        wait_cnt_d = '0;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (hold_pc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= PIPE_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned TB_TO    = 16;
  localparam int unsigned TB_CNT_W = 6;

  // {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}
  localparam logic [7:0] V_NONE = 8'b0000_0000;
  localparam logic [7:0] V_MEM  = 8'b1111_0001;
  localparam logic [7:0] V_DIV  = 8'b1110_0010;
  localparam logic [7:0] V_JMP  = 8'b0000_1100;
  localparam logic [7:0] V_LU   = 8'b1100_0100;
  localparam logic [7:0] V_ABRT = 8'b0000_0001;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_reg_w_addr = '0;
  logic id_rs1_used = 0, id_rs2_used = 0, ex_load = 0, ex_jump = 0;
  logic mem_req = 0, mem_ready = 0, div_start = 0, div_done = 0;
  logic hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic mem_timeout;
  logic [TB_CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(TB_TO), .CNT_W(TB_CNT_W)) dut (
    .clk_100MHz(clk), .arst_n(arst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_load(ex_load), .ex_reg_w_addr(ex_reg_w_addr), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .div_start(div_start), .div_done(div_done),
    .hold_pc(hold_pc), .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex),
    .hold_ex_mem(hold_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  wire [7:0] dut_vec = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem,
                        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

  // ---------------- behavioural model ----------------
  bit                  m_in_mem = 0;   // a memory access is being waited on
  bit                  m_in_div = 0;   // the divider is being waited on
  int                  m_waited = 0;   // cycles already spent waiting after the first
  bit                  m_to     = 0;
  logic [TB_CNT_W-1:0] m_stall  = '0;

  function automatic bit load_use_now();
    if (!ex_load || ex_reg_w_addr == 0) return 0;
    return (id_rs1_used && id_rs1_addr == ex_reg_w_addr) ||
           (id_rs2_used && id_rs2_addr == ex_reg_w_addr);
  endfunction

  function automatic bit abort_now();
    return m_in_mem && !mem_ready && (m_waited == TB_TO - 1);
  endfunction

  function automatic logic [7:0] exp_vec();
    bit ms;
    ms = mem_req && !mem_ready;
    if (m_in_mem) begin
      if (mem_ready) return V_NONE;
      if (abort_now()) return V_ABRT;
      return V_MEM;
    end
    if (m_in_div) begin
      if (ms) return V_MEM;
      if (div_done) return V_NONE;
      return V_DIV;
    end
    if (ms) return V_MEM;
    if (div_start && !div_done) return V_DIV;
    if (ex_jump) return V_JMP;
    if (load_use_now()) return V_LU;
    return V_NONE;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_in_mem = 0; m_in_div = 0; m_waited = 0; m_to = 0; m_stall = '0;
    end else begin
      logic [7:0] v;
      bit ab;
      v  = exp_vec();
      ab = abort_now();
      if (v[7] && m_stall != {TB_CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
      m_to = ab;
      if (m_in_mem) begin
        if (mem_ready || ab) m_in_mem = 0;
        else m_waited = m_waited + 1;
      end else if (m_in_div) begin
        if (div_done) m_in_div = 0;
      end else if (mem_req && !mem_ready) begin
        m_in_mem = 1; m_waited = 0;
      end else if (div_start && !div_done) begin
        m_in_div = 1;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (arst_n && chk_en) begin
      logic [7:0] ev;
      ev = exp_vec();
      checks++;
      if (dut_vec !== ev) begin
        errors++;
        $display("FAIL model_outs t=%0t: got %b expected %b", $time, dut_vec, ev);
      end
      checks++;
      if (mem_timeout !== m_to) begin
        errors++;
        $display("FAIL model_timeout t=%0t: got %b expected %b", $time, mem_timeout, m_to);
      end
      checks++;
      if (stall_cnt !== m_stall) begin
        errors++;
        $display("FAIL model_stall t=%0t: got %0d expected %0d", $time, stall_cnt, m_stall);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_load = 0; ex_reg_w_addr = 0; ex_jump = 0;
    mem_req = 0; mem_ready = 0; div_start = 0; div_done = 0;
  endtask

  // Memory access that never completes: 16 held cycles, abort, timeout pulse.
  task automatic run_timeout(input int base);
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      #1 chk("to_hold", {31'b0, hold_ex_mem}, 1);
      step();
    end
    #1 chk("to_abort_outs", {24'b0, dut_vec}, {24'b0, V_ABRT});
    chk("to_no_pulse_yet", {31'b0, mem_timeout}, 0);
    step();
    set_idle();
    #1 chk("to_pulse", {31'b0, mem_timeout}, 1);
    chk("to_stall", {26'b0, stall_cnt}, base + 16);
    step();
    #1 chk("to_pulse_end", {31'b0, mem_timeout}, 0);
  endtask

  initial begin
    set_idle();
    arst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outs", {24'b0, dut_vec}, 0);
    chk("rst_timeout", {31'b0, mem_timeout}, 0);
    chk("rst_stall", {26'b0, stall_cnt}, 0);
    arst_n = 1;
    chk_en = 1;
    step();

    // Load-use: one bubble.
    ex_load = 1; ex_reg_w_addr = 5; id_rs1_addr = 5; id_rs1_used = 1;
    #1 chk("lu_outs", {24'b0, dut_vec}, {24'b0, V_LU});
    step();
    set_idle();
    #1 chk("lu_after", {24'b0, dut_vec}, 0);
    chk("lu_stall", {26'b0, stall_cnt}, 1);

    // Load targeting x0: no stall.
    ex_load = 1; ex_reg_w_addr = 0; id_rs1_addr = 0; id_rs1_used = 1;
    #1 chk("lu_x0", {24'b0, dut_vec}, 0);
    step();

    // Jump with a matching load-use: jump wins.
    ex_load = 1; ex_reg_w_addr = 7; id_rs2_addr = 7; id_rs2_used = 1; ex_jump = 1;
    #1 chk("jmp_lu", {24'b0, dut_vec}, {24'b0, V_JMP});
    step();
    set_idle();

    // Memory wait: 3 held cycles then ready.
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_hold", {31'b0, hold_ex_mem}, 1);
      step();
    end
    mem_ready = 1;
    #1 chk("mw_ready", {24'b0, dut_vec}, 0);
    step();
    set_idle();
    #1 chk("mw_stall", {26'b0, stall_cnt}, 4);
    chk("mw_back_run", {24'b0, dut_vec}, 0);

    run_timeout(4);

    // Divider: 8 held cycles.
    div_start = 1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("div_hold", {24'b0, dut_vec}, {24'b0, V_DIV});
      step();
    end
    div_done = 1;
    #1 chk("div_done", {24'b0, dut_vec}, 0);
    step();
    set_idle();
    #1 chk("div_stall", {26'b0, stall_cnt}, 28);

    // Memory stall in the middle of a divide takes the outputs.
    div_start = 1;
    step(); step();
    mem_req = 1; mem_ready = 0;
    #1 chk("div_mem_a", {24'b0, dut_vec}, {24'b0, V_MEM});
    step();
    #1 chk("div_mem_b", {24'b0, dut_vec}, {24'b0, V_MEM});
    step();
    mem_req = 0;
    #1 chk("div_resume", {24'b0, dut_vec}, {24'b0, V_DIV});
    step();
    div_done = 1;
    #1 chk("div_end", {24'b0, dut_vec}, 0);
    step();
    set_idle();

    // Reset while in MEM_WAIT at wait_cnt=5.
    mem_req = 1; mem_ready = 0;
    repeat (6) step();
    set_idle();
    arst_n = 0;
    #1 chk("rst_mw_stall", {26'b0, stall_cnt}, 0);
    chk("rst_mw_timeout", {31'b0, mem_timeout}, 0);
    chk("rst_mw_outs", {24'b0, dut_vec}, 0);
    #1 arst_n = 1;
    step();
    run_timeout(0);

    // Random phase.
    for (int c = 0; c < 4000; c++) begin
      id_rs1_addr   = 5'($urandom_range(0, 3));
      id_rs2_addr   = 5'($urandom_range(0, 3));
      ex_reg_w_addr = 5'($urandom_range(0, 3));
      id_rs1_used   = 1'($urandom_range(0, 1));
      id_rs2_used   = 1'($urandom_range(0, 1));
      ex_load       = ($urandom_range(0, 9) < 4);
      ex_jump       = ($urandom_range(0, 9) < 2);
      mem_req       = ($urandom_range(0, 9) < 3);
      mem_ready     = ($urandom_range(0, 9) == 0);
      div_start     = ($urandom_range(0, 9) < 2);
      div_done      = ($urandom_range(0, 19) < 3);
      step();
    end

    set_idle();
    step();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
